// File: rtl/lane_pkg.sv
// Shared lane types for the byte mux stage and its downstream serializer.
package lane_pkg;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;

  typedef logic [LANE_W-1:0] byte_t;
  typedef byte_t lanes_t [NUM_LANES-1:0];

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/lane_serializer_if.sv
// Parallel-frame input and serial-byte output handshakes of the lane serializer.
interface lane_serializer_if #(
  parameter int W     = lane_pkg::LANE_W,
  parameter int LANES = lane_pkg::NUM_LANES,
  parameter int CW    = 8
);

  logic [W-1:0]  in_lanes [LANES-1:0];
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [CW-1:0] frame_cnt;

  modport slave (
    input  in_lanes, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, frame_cnt
  );

  modport master (
    output in_lanes, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, frame_cnt
  );

endinterface

// File: rtl/mod_counter.sv
// Free-running wrap counter, advances by one on each cycle inc is high.
// Registered output, wraps 2^CW-1 -> 0; no backpressure.
module mod_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/lane_serializer.sv
// Serializes a LANES-byte frame lane 0 first; 1-cycle in-to-out latency, back-to-back frames without bubbles.
// out_ready low holds the current byte and drops in_ready; in_ready is combinational from out_ready on the last byte.
module lane_serializer
  import lane_pkg::*;
#(
  parameter int W     = LANE_W,
  parameter int LANES = NUM_LANES,
  parameter int CW    = 8
) (
  input  logic clk,
  input  logic rst_n,
  lane_serializer_if.slave bus
);

  localparam int             IW       = $clog2(LANES);
  localparam logic [IW-1:0]  LAST_IDX = IW'(LANES - 1);

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d, idx_nxt;
  logic [W-1:0]   buf_q [LANES-1:0];
  logic [W-1:0]   buf_d [LANES-1:0];
  logic [W-1:0]   data_q, data_d;
  logic           last_q, last_d;
  logic           in_ready_c;
  logic           frame_done;
  logic [CW-1:0]  cnt;

  assign idx_nxt = idx_q + IW'(1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    data_d     = data_q;
    last_d     = last_q;
    in_ready_c = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      IDLE: in_ready_c = 1'b1;
      SHIFT: begin
        if (bus.out_ready) begin
          if (idx_q == LAST_IDX) begin
            frame_done = 1'b1;
            in_ready_c = 1'b1;
            state_d    = IDLE;
            idx_d      = '0;
            data_d     = '0;
            last_d     = 1'b0;
          end else begin
            idx_d  = idx_nxt;
            data_d = buf_q[idx_nxt];
            last_d = (idx_nxt == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new frame overrides the return to IDLE, giving the no-bubble handover.
    if (in_ready_c && bus.in_valid) begin
      state_d = SHIFT;
      idx_d   = '0;
      buf_d   = bus.in_lanes;
      data_d  = bus.in_lanes[0];
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      for (int i = 0; i < LANES; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
      buf_q   <= buf_d;
    end
  end

  mod_counter #(.CW(CW)) u_frame_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (frame_done),
    .cnt   (cnt)
  );

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == SHIFT);
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
  assign bus.frame_cnt = cnt;

endmodule

// File: doc/lane_serializer.md
Name: lane_serializer

Overview:
- Downstream consumer of the 4-lane byte mux stage.
- Captures one parallel frame of LANES bytes, `in_lanes[0..LANES-1]`, with a valid/ready handshake.
- Emits the frame as a byte stream, lane 0 first, one byte per accepted cycle, on an output valid/ready interface.
- Flags the last byte of each frame and keeps a running count of completed frames.

Parameters:
- W, 8, byte/lane width in bits.
- LANES, 4, lanes per frame; must be at least 2.
- CW, 8, width of the frame counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_lanes  input  W x LANES (unpacked array [LANES-1:0] of [W-1:0])  parallel frame from the mux stage.
- in_valid  input  1  frame on in_lanes is valid.
- in_ready  output  1  block accepts a frame this cycle.
- out_data  output  W  current serial byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_last  output  1  out_data is the final lane (LANES-1) of the frame.
- frame_cnt  output  CW  number of fully emitted frames, modulo 2^CW.

Behaviour:
- Reset is synchronous and active-low: rst_n sampled low at a clk edge returns the block to reset state.
- Reset values:
  - state=IDLE, idx=0, buffer=0.
  - out_valid=0, out_data=0, out_last=0, frame_cnt=0.
  - in_ready=1 in the cycle after reset is released.
- Handshakes: an input transfer occurs when in_valid&in_ready at a clk edge; an output transfer when out_valid&out_ready.
- State machine with states IDLE and SHIFT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an input transfer: copy all lanes into buffer, idx<=0, go to SHIFT.
  - out_valid=1 from the next cycle, i.e. 1-cycle input-to-output latency.
- SHIFT:
  - out_valid=1, out_data=buffer[idx], out_last=(idx==LANES-1).
  - On an output transfer with idx<LANES-1: idx<=idx+1.
  - On an output transfer with idx==LANES-1: frame_cnt<=frame_cnt+1, wrapping 2^CW-1 -> 0.
    - If in_valid is also high that cycle: load the new frame, idx<=0, stay in SHIFT (back-to-back, no bubble).
    - Otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==SHIFT & idx==LANES-1 & out_ready). This is combinational from out_ready; it is the only combinational input-to-output path.
- With out_ready held at 1 and in_valid held at 1, a frame occupies exactly LANES cycles.
- Stall (out_valid&!out_ready): out_data, out_last, idx and buffer hold; in_ready=0.
- in_lanes is sampled only on an input transfer; changes at any other time have no effect.
- An all-zero frame (upstream mux blanked by its EN=1) is serialized like any other frame, with no special casing.
- Reset mid-frame: remaining bytes are discarded and frame_cnt is not incremented for the partial frame.
- out_data is registered and equals 0 whenever out_valid=0.

Decomposition:
- Shared package lane_pkg:
  - W and LANES defaults.
  - typedef of the byte type.
  - typedef of the lane array type, shared with the mux stage.
  - state enum {IDLE, SHIFT}.
- idx width is $clog2(LANES).
- No sub-module required.
- Optional: factor the frame counter as a generic wrap counter, mod_counter, with parameter CW and input inc.

Test Plan:
- Reset: hold rst_n=0 for 2 clk with in_valid=1 -> out_valid=0, out_data=0, frame_cnt=0; in_ready=1 after release.
- Single frame: in_lanes={0x04,0x03,0x02,0x01} (lane3..lane0), in_valid one cycle, out_ready=1 -> next 4 cycles out_data=0x01,0x02,0x03,0x04; out_last only on 0x04; frame_cnt=1; then IDLE.
- Back-to-back: in_valid=1 continuously with frames A={0..3} and B={4..7}, out_ready=1 -> 8 consecutive valid bytes 0..7 with no gap; in_ready pulses only in the last-byte cycle; frame_cnt=2.
- Backpressure: drop out_ready for 3 cycles on byte 2 -> out_data holds 0x02 and in_ready=0 throughout; byte order is preserved after release.
- Reset mid-frame: assert rst_n=0 after byte 1 is accepted -> out_valid=0 next cycle and frame_cnt unchanged; a subsequent frame starts again from lane 0.
- Counter wrap (CW=2): send 5 frames -> frame_cnt sequence 1,2,3,0,1.
